// File: rtl/ip_sequencer.sv
// ip_sequencer
//   Run-control FSM for the 4-bit instruction pointer / program ROM unit.
//   Each instruction takes two clocks: DECODE latches the ROM word and
//   EXEC strobes the pointer (set = jump to memaddr, next = increment).
//   A loop counter is tested by IF and decremented by DEC, and a step
//   watchdog aborts runaway programs with a sticky err flag.
//
// Ports
//   clock     in   rising-edge clock shared with the pointer unit
//   reset_n   in   asynchronous active-low reset
//   start     in   begin a run; only looked at in IDLE
//   cnt_init  in   loop counter load value, captured with an accepted start
//   com       in   opcode at the pointer: 00 NOP, 01 DEC, 10 IF, 11 HALT
//   memaddr   in   jump target at the pointer, loaded by the pointer on set
//   set       out  pointer loads memaddr this cycle (EXEC only)
//   next      out  pointer increments this cycle (EXEC only)
//   busy      out  run in progress (DECODE or EXEC)
//   done      out  one-cycle pulse after HALT is decoded
//   err       out  sticky watchdog abort flag, cleared by the next accepted start
//   loop_cnt  out  current loop counter
//   step_cnt  out  instructions executed in this run (HALT not counted)

module ip_sequencer #(
  parameter int CNT_W     = 8,
  parameter int STEP_W    = 8,
  parameter int MAX_STEPS = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cnt_init,
  input  logic [1:0]        com,
  input  logic [3:0]        memaddr,
  output logic              set,
  output logic              next,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  loop_cnt,
  output logic [STEP_W-1:0] step_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_IF   = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  loop_cnt_q, loop_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              err_q, err_d;
  logic [1:0]        com_q, com_d;
  logic [3:0]        addr_q, addr_d;

  logic              jump_taken;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      loop_cnt_q <= '0;
      step_cnt_q <= '0;
      err_q      <= 1'b0;
      com_q      <= OP_NOP;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      loop_cnt_q <= loop_cnt_d;
      step_cnt_q <= step_cnt_d;
      err_q      <= err_d;
      com_q      <= com_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    loop_cnt_d = loop_cnt_q;
    step_cnt_d = step_cnt_q;
    err_d      = err_q;
    com_d      = com_q;
    addr_d     = addr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          loop_cnt_d = cnt_init;
          step_cnt_d = '0;
          err_d      = 1'b0;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // The watchdog is tested before HALT so a program that reaches
        // the limit aborts even if its next word would have halted it.
        if (step_cnt_q == STEP_LIMIT) begin
          state_d = S_ERROR;
        end else if (com == OP_HALT) begin
          state_d = S_DONE;
        end else begin
          com_d   = com;
          addr_d  = memaddr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        step_cnt_d = step_cnt_q + 1'b1;
        // DEC saturates at zero so a stray DEC can never arm an IF loop.
        if (com_q == OP_DEC && loop_cnt_q != '0) begin
          loop_cnt_d = loop_cnt_q - 1'b1;
        end
        state_d = S_DECODE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERROR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // IF uses the loop count held before this cycle's edge; strobes come
  // straight from registers so a reset removes them immediately.
  assign jump_taken = (com_q == OP_IF) && (loop_cnt_q != '0);
  assign set        = (state_q == S_EXEC) && jump_taken;
  assign next       = (state_q == S_EXEC) && !jump_taken;
  assign busy       = (state_q == S_DECODE) || (state_q == S_EXEC);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign loop_cnt   = loop_cnt_q;
  assign step_cnt   = step_cnt_q;

  // The pointer only moves on the edge that ends EXEC, so the word seen
  // during EXEC must still be the one latched in DECODE; memaddr is what
  // the pointer loads when set is high.
  a_word_stable_in_exec: assert property (
    @(posedge clock) disable iff (!reset_n)
      (state_q == S_EXEC) |-> (memaddr == addr_q && com == com_q)
  );

endmodule

// File: tb/tb_ip_sequencer.sv
// tb_ip_sequencer
//   Drives ip_sequencer against a behavioural pointer + ROM model.
//   Stimulus pushes the hand-derived expected events (each EXEC strobe,
//   the done pulse, the watchdog abort) into a queue; a monitor on the
//   falling edge pops and compares whenever the DUT presents one.

module tb_ip_sequencer;

  localparam int CNT_W  = 8;
  localparam int STEP_W = 8;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_IF   = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  logic              clock    = 1'b0;
  logic              reset_n  = 1'b1;
  logic              start    = 1'b0;
  logic [CNT_W-1:0]  cnt_init = '0;
  logic [1:0]        com;
  logic [3:0]        memaddr;
  logic              set;
  logic              next;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  loop_cnt;
  logic [STEP_W-1:0] step_cnt;

  ip_sequencer #(
    .CNT_W     (CNT_W),
    .STEP_W    (STEP_W),
    .MAX_STEPS (255)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .cnt_init (cnt_init),
    .com      (com),
    .memaddr  (memaddr),
    .set      (set),
    .next     (next),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .loop_cnt (loop_cnt),
    .step_cnt (step_cnt)
  );

  always #5 clock = ~clock;

  // Behavioural pointer unit and program ROM.
  logic [1:0] rom_com  [16];
  logic [3:0] rom_addr [16];
  logic [3:0] ptr;
  logic       ptr_clr = 1'b0;

  assign com     = rom_com[ptr];
  assign memaddr = rom_addr[ptr];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)     ptr <= 4'd0;
    else if (set)     ptr <= memaddr;
    else if (next)    ptr <= ptr + 4'd1;
    else if (ptr_clr) ptr <= 4'd0;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard.
  typedef enum int {EV_STROBE, EV_DONE, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       addr;
    int       is_set;
    int       step;
    int       loop;
    int       rel_cyc;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   e0         = 0;
  logic prev_done  = 1'b0;
  logic prev_err   = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic pushStrobe(input int addr, input int is_set);
    exp_t e;
    e = '{kind: EV_STROBE, addr: addr, is_set: is_set, step: 0, loop: 0, rel_cyc: 0};
    sb.push_back(e);
  endtask

  task automatic pushEnd(input ev_kind_e kind, input int step, input int loop, input int rel);
    exp_t e;
    e = '{kind: kind, addr: 0, is_set: 0, step: step, loop: loop, rel_cyc: rel};
    sb.push_back(e);
  endtask

  task automatic popAndCheck(input ev_kind_e kind);
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unexpected_event: got %s, expected none (t=%0t)", kind.name(), $time);
    end else begin
      e = sb.pop_front();
      checkOutput("event_kind", int'(kind), int'(e.kind));
      if (kind == EV_STROBE) begin
        checkOutput("strobe_addr", int'(ptr), e.addr);
        checkOutput("strobe_is_set", int'(set), e.is_set);
      end else begin
        checkOutput("end_step_cnt", int'(step_cnt), e.step);
        checkOutput("end_loop_cnt", int'(loop_cnt), e.loop);
        checkOutput("end_cycle", cyc - e0, e.rel_cyc);
        checkOutput("end_busy", int'(busy), 0);
        if (kind == EV_DONE) checkOutput("done_err", int'(err), 0);
      end
    end
  endtask

  // Monitor: invariants every cycle, plus event matching.
  always @(negedge clock) begin
    checkOutput("set_next_exclusive", int'(set && next), 0);
    checkOutput("strobe_outside_busy", int'((set || next) && !busy), 0);
    checkOutput("done_width", int'(done && prev_done), 0);
    if (set || next)    popAndCheck(EV_STROBE);
    if (done)           popAndCheck(EV_DONE);
    if (err && !prev_err) popAndCheck(EV_ERR);
    prev_done = done;
    prev_err  = err;
  end

  task automatic loadMain();
    for (int i = 0; i < 16; i++) begin
      rom_com[i]  = OP_HALT;
      rom_addr[i] = 4'd0;
    end
    rom_com[0]  = OP_NOP;
    rom_com[1]  = OP_NOP;
    rom_com[2]  = OP_DEC;
    rom_com[3]  = OP_IF;
    rom_addr[3] = 4'd2;
    rom_com[4]  = OP_HALT;
  endtask

  task automatic clearPtr();
    @(negedge clock);
    ptr_clr = 1'b1;
    @(negedge clock);
    ptr_clr = 1'b0;
  endtask

  // cnt_init=3: trace 0,1,2,3,2,3,2,3 then HALT at 4, done after E0+17.
  task automatic pushScenario1();
    int addrs [8] = '{0, 1, 2, 3, 2, 3, 2, 3};
    int sets  [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
    for (int i = 0; i < 8; i++) pushStrobe(addrs[i], sets[i]);
    pushEnd(EV_DONE, 8, 0, 17);
  endtask

  // cnt_init=0: DEC saturates, IF falls through, done after E0+9.
  task automatic pushScenario2();
    for (int i = 0; i < 4; i++) pushStrobe(i, 0);
    pushEnd(EV_DONE, 4, 0, 9);
  endtask

  task automatic applyStimulus(input int init, input bit hold_start);
    @(negedge clock);
    cnt_init = CNT_W'(init);
    start    = 1'b1;
    @(negedge clock);
    e0 = cyc;
    if (!hold_start) start = 1'b0;
  endtask

  task automatic waitIdle(input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && !busy && !done) break;
    end
    checkOutput({name, "_pending_events"}, sb.size(), 0);
    checkOutput({name, "_busy_at_end"}, int'(busy), 0);
    sb.delete();
  endtask

  initial begin
    loadMain();
    #1 reset_n = 1'b0;
    #2;
    checkOutput("reset_set", int'(set), 0);
    checkOutput("reset_next", int'(next), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_loop_cnt", int'(loop_cnt), 0);
    checkOutput("reset_step_cnt", int'(step_cnt), 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] scenario 1: loop of three");
    clearPtr();
    pushScenario1();
    applyStimulus(3, 1'b0);
    waitIdle(100, "run1");

    $display("[TB] scenario 2: zero loop count");
    clearPtr();
    pushScenario2();
    applyStimulus(0, 1'b0);
    waitIdle(100, "run2");

    $display("[TB] scenario 3: watchdog");
    for (int i = 0; i < 16; i++) begin
      rom_com[i]  = OP_HALT;
      rom_addr[i] = 4'd0;
    end
    rom_com[0] = OP_IF;
    clearPtr();
    for (int i = 0; i < 255; i++) pushStrobe(0, 1);
    pushEnd(EV_ERR, 255, 5, 512);
    applyStimulus(5, 1'b0);
    waitIdle(700, "run3");
    checkOutput("wd_err_sticky", int'(err), 1);
    checkOutput("wd_done_low", int'(done), 0);
    loadMain();
    clearPtr();
    checkOutput("wd_err_still_set", int'(err), 1);
    pushScenario2();
    applyStimulus(0, 1'b0);
    checkOutput("err_cleared_by_start", int'(err), 0);
    waitIdle(100, "run3b");

    $display("[TB] scenario 4: start held high");
    clearPtr();
    pushScenario1();
    applyStimulus(3, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done) break;
    end
    checkOutput("held_done_seen", int'(done), 1);
    @(negedge clock);
    checkOutput("start_in_done_ignored", int'(busy), 0);
    checkOutput("held_step_cnt", int'(step_cnt), 8);
    start = 1'b0;
    @(negedge clock);
    checkOutput("held_idle_after", int'(busy), 0);
    checkOutput("held_pending_events", sb.size(), 0);
    sb.delete();

    $display("[TB] scenario 5: reset during IF execution");
    clearPtr();
    pushStrobe(0, 0);
    pushStrobe(1, 0);
    pushStrobe(2, 0);
    pushStrobe(3, 1);
    applyStimulus(3, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (set) break;
    end
    checkOutput("reached_if_exec", int'(set), 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_reset_set", int'(set), 0);
    checkOutput("mid_reset_next", int'(next), 0);
    checkOutput("mid_reset_busy", int'(busy), 0);
    checkOutput("mid_reset_done", int'(done), 0);
    checkOutput("mid_reset_err", int'(err), 0);
    checkOutput("mid_reset_loop_cnt", int'(loop_cnt), 0);
    checkOutput("mid_reset_step_cnt", int'(step_cnt), 0);
    checkOutput("mid_reset_pending", sb.size(), 0);
    sb.delete();
    @(negedge clock);
    reset_n = 1'b1;
    pushScenario2();
    applyStimulus(0, 1'b0);
    waitIdle(100, "run5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
